// File: rtl/salsa_pkg.sv
// Shared Salsa20 types, rotation constants and quarterround word-index tables.
package salsa_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned NUM_QR    = 4;
  localparam int unsigned QR_ARGS   = 4;

  typedef logic [WORD_W-1:0] word_t;
  // Packed so word i sits at bits [32*i+31 : 32*i].
  typedef word_t [NUM_WORDS-1:0] state_t;
  typedef logic [3:0] idx_t;

  localparam int unsigned ROT_1 = 7;
  localparam int unsigned ROT_2 = 9;
  localparam int unsigned ROT_3 = 13;
  localparam int unsigned ROT_4 = 18;

  // Column (odd) round groups, each in QR argument order (a, b, c, d).
  localparam idx_t COL_IDX [NUM_QR][QR_ARGS] = '{
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd5,  4'd9,  4'd13, 4'd1 },
    '{4'd10, 4'd14, 4'd2,  4'd6 },
    '{4'd15, 4'd3,  4'd7,  4'd11}
  };

  // Row (even) round groups, each in QR argument order (a, b, c, d).
  localparam idx_t ROW_IDX [NUM_QR][QR_ARGS] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3 },
    '{4'd5,  4'd6,  4'd7,  4'd4 },
    '{4'd10, 4'd11, 4'd8,  4'd9 },
    '{4'd15, 4'd12, 4'd13, 4'd14}
  };

  // Left rotate of a 32-bit word by a constant amount (1..31).
  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/salsa_round_if.sv
// Round request/result bundle between the hash core and salsa_round.
interface salsa_round_if;
  import salsa_pkg::*;

  logic   in_valid;
  logic   even;
  state_t data_in;
  logic   out_valid;
  state_t data_out;

  modport master (output in_valid, even, data_in, input out_valid, data_out);
  modport slave  (input in_valid, even, data_in, output out_valid, data_out);
endinterface

// File: rtl/salsa_quarterround.sv
// Combinational Salsa20 quarterround; each step feeds the next in the fixed b, c, d, a order.
module salsa_quarterround
  import salsa_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_out,
  output word_t b_out,
  output word_t c_out,
  output word_t d_out
);

  word_t b1;
  word_t c1;
  word_t d1;
  word_t a1;

  assign b1 = b ^ rotl(a + d,   ROT_1);
  assign c1 = c ^ rotl(b1 + a,  ROT_2);
  assign d1 = d ^ rotl(c1 + b1, ROT_3);
  assign a1 = a ^ rotl(d1 + c1, ROT_4);

  assign a_out = a1;
  assign b_out = b1;
  assign c_out = c1;
  assign d_out = d1;

endmodule

// File: rtl/salsa_round.sv
// One Salsa20 column (even=0) or row (even=1) round over a 512-bit state.
// Build option: SALSA_ROUND_OUTREG_EN adds a 1-cycle output register stage;
// without it the block is purely combinational and clk/reset are unused.
module salsa_round
  import salsa_pkg::*;
(
  input logic         clk,
  input logic         reset,
  salsa_round_if.slave bus
);

  state_t st_in;
  state_t rnd;
  idx_t   sel_idx [NUM_QR][QR_ARGS];
  word_t  qin     [NUM_QR][QR_ARGS];
  word_t  qout    [NUM_QR][QR_ARGS];

  assign st_in = bus.data_in;

  // Pick the word group of each quarterround from the column or row table.
  always_comb begin
    for (int q = 0; q < NUM_QR; q++) begin
      for (int k = 0; k < QR_ARGS; k++) begin
        sel_idx[q][k] = bus.even ? ROW_IDX[q][k] : COL_IDX[q][k];
        qin[q][k]     = st_in[sel_idx[q][k]];
      end
    end
  end

  for (genvar g = 0; g < NUM_QR; g++) begin : g_qr
    salsa_quarterround u_qr (
      .a     (qin[g][0]),
      .b     (qin[g][1]),
      .c     (qin[g][2]),
      .d     (qin[g][3]),
      .a_out (qout[g][0]),
      .b_out (qout[g][1]),
      .c_out (qout[g][2]),
      .d_out (qout[g][3])
    );
  end

  // Scatter results back; each word is written by exactly one quarterround.
  always_comb begin
    rnd = '0;
    for (int q = 0; q < NUM_QR; q++) begin
      for (int k = 0; k < QR_ARGS; k++) begin
        rnd[sel_idx[q][k]] = qout[q][k];
      end
    end
  end

`ifdef SALSA_ROUND_OUTREG_EN
  // Output stage: reset wins, result captured only for valid input, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.data_out <= rnd;
      end
    end
  end
`else
  // Combinational build: the enclosing core registers the result.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign bus.out_valid    = bus.in_valid;
  assign bus.data_out     = rnd;
`endif

endmodule

// File: tb/tb_salsa_round.sv
// Directed self-checking bench for salsa_round (registered or combinational build).
module tb_salsa_round;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  salsa_round_if bus ();

  salsa_round u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Independent reference model, written directly from the Salsa20 definition.
  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    logic [63:0] dbl;
    dbl = {v, v} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] nb, nc, nd, na;
    nb = b ^ rl(a + d, 7);
    nc = c ^ rl(nb + a, 9);
    nd = d ^ rl(nc + nb, 13);
    na = a ^ rl(nd + nc, 18);
    return {na, nb, nc, nd};
  endfunction

  function automatic logic [511:0] model_round(input logic [511:0] s, input logic ev);
    logic [31:0]  x [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    if (!ev) begin
      {x[0],  x[4],  x[8],  x[12]} = qr(x[0],  x[4],  x[8],  x[12]);
      {x[5],  x[9],  x[13], x[1]}  = qr(x[5],  x[9],  x[13], x[1]);
      {x[10], x[14], x[2],  x[6]}  = qr(x[10], x[14], x[2],  x[6]);
      {x[15], x[3],  x[7],  x[11]} = qr(x[15], x[3],  x[7],  x[11]);
    end else begin
      {x[0],  x[1],  x[2],  x[3]}  = qr(x[0],  x[1],  x[2],  x[3]);
      {x[5],  x[6],  x[7],  x[4]}  = qr(x[5],  x[6],  x[7],  x[4]);
      {x[10], x[11], x[8],  x[9]}  = qr(x[10], x[11], x[8],  x[9]);
      {x[15], x[12], x[13], x[14]} = qr(x[15], x[12], x[13], x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  function automatic logic [511:0] put_w(input logic [511:0] s, input int i, input logic [31:0] v);
    logic [511:0] r;
    r = s;
    r[32*i +: 32] = v;
    return r;
  endfunction

  task automatic drive(input logic v, input logic ev, input logic [511:0] d);
    bus.in_valid = v;
    bus.even     = ev;
    bus.data_in  = d;
  endtask

  // Observation point: just after the active edge.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0);
    settle();
    settle();
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.data_out !== 512'h0) begin
      errors++;
      $display("FAIL reset_data_out: got %h expected 0", bus.data_out);
    end
  endtask

  task automatic test_vectors();
    logic [511:0] din, exp;
    // Odd round, x0 = 1
    din = put_w('0, 0, 32'h1);
    exp = put_w(put_w(put_w(put_w('0, 0, 32'h08008145), 4, 32'h00000080),
                      8, 32'h00010200), 12, 32'h20500000);
    drive(1'b1, 1'b0, din);
    settle();
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL odd_x0: got %h expected %h", bus.data_out, exp);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL odd_x0_valid: got %b expected 1", bus.out_valid);
    end
    // Even round, x0 = 1
    exp = put_w(put_w(put_w(put_w('0, 0, 32'h08008145), 1, 32'h00000080),
                      2, 32'h00010200), 3, 32'h20500000);
    drive(1'b1, 1'b1, din);
    settle();
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL even_x0: got %h expected %h", bus.data_out, exp);
    end
    // Odd round, x4 = 1
    din = put_w('0, 4, 32'h1);
    exp = put_w(put_w(put_w(put_w('0, 0, 32'h88000100), 4, 32'h00000001),
                      8, 32'h00000200), 12, 32'h00402000);
    drive(1'b1, 1'b0, din);
    settle();
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL odd_x4: got %h expected %h", bus.data_out, exp);
    end
  endtask

  task automatic test_zero_latency();
    logic exp_before, exp_after_drop;
`ifdef SALSA_ROUND_OUTREG_EN
    exp_before     = 1'b0;
    exp_after_drop = 1'b1;
`else
    exp_before     = 1'b1;
    exp_after_drop = 1'b0;
`endif
    drive(1'b0, 1'b0, '0);
    settle();
    drive(1'b1, 1'b1, '0);
    #1;
    checks++;
    if (bus.out_valid !== exp_before) begin
      errors++;
      $display("FAIL latency_pre_edge: got %b expected %b", bus.out_valid, exp_before);
    end
    settle();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_post_edge: got %b expected 1", bus.out_valid);
    end
    checks++;
    if (bus.data_out !== 512'h0) begin
      errors++;
      $display("FAIL zero_even: got %h expected 0", bus.data_out);
    end
    drive(1'b1, 1'b0, '0);
    settle();
    checks++;
    if (bus.data_out !== 512'h0) begin
      errors++;
      $display("FAIL zero_odd: got %h expected 0", bus.data_out);
    end
    drive(1'b0, 1'b0, '0);
    #1;
    checks++;
    if (bus.out_valid !== exp_after_drop) begin
      errors++;
      $display("FAIL latency_drop: got %b expected %b", bus.out_valid, exp_after_drop);
    end
    settle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] cur, exp;
    logic [31:0]  init [16];
    init = '{32'h61707865, 32'h04030201, 32'h08070605, 32'h0c0b0a09,
             32'h100f0e0d, 32'h3320646e, 32'h01040103, 32'h06020905,
             32'h00000007, 32'h00000000, 32'h79622d32, 32'h14131211,
             32'h18171615, 32'h1c1b1a19, 32'h201f1e1d, 32'h6b206574};
    for (int i = 0; i < 16; i++) cur[32*i +: 32] = init[i];
    for (int r = 0; r < 20; r++) begin
      exp = model_round(cur, (r % 2) == 1);
      drive(1'b1, (r % 2) == 1, cur);
      settle();
      checks++;
      if (bus.data_out !== exp || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_round%0d: got v=%b %h expected v=1 %h", r, bus.out_valid, bus.data_out, exp);
      end
      cur = exp;
    end
  endtask

  task automatic test_reset_priority();
    logic [511:0] d0, d4, held, exp_rst, exp_idle;
    logic         exp_rst_v;
    d0   = put_w('0, 0, 32'h1);
    d4   = put_w('0, 4, 32'h1);
    held = put_w(put_w(put_w(put_w('0, 0, 32'h08008145), 4, 32'h00000080),
                       8, 32'h00010200), 12, 32'h20500000);
`ifdef SALSA_ROUND_OUTREG_EN
    exp_rst   = '0;
    exp_rst_v = 1'b0;
    exp_idle  = held;
`else
    exp_rst   = model_round(d4, 1'b1);
    exp_rst_v = 1'b1;
    exp_idle  = model_round(d4, 1'b1);
`endif
    drive(1'b1, 1'b0, d0);
    settle();
    reset = 1'b1;
    drive(1'b1, 1'b1, d4);
    settle();
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== exp_rst_v) begin
      errors++;
      $display("FAIL reset_prio_valid: got %b expected %b", bus.out_valid, exp_rst_v);
    end
    checks++;
    if (bus.data_out !== exp_rst) begin
      errors++;
      $display("FAIL reset_prio_data: got %h expected %h", bus.data_out, exp_rst);
    end
    drive(1'b1, 1'b0, d0);
    settle();
    checks++;
    if (bus.data_out !== held) begin
      errors++;
      $display("FAIL after_reset_data: got %h expected %h", bus.data_out, held);
    end
    drive(1'b0, 1'b1, d4);
    settle();
    settle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.data_out !== exp_idle) begin
      errors++;
      $display("FAIL hold_data: got %h expected %h", bus.data_out, exp_idle);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_vectors();
    test_zero_latency();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
